// File: rtl/imm_gen_pkg.sv
// Shared types and the reference immediate extraction for the RISC-V decode-stage
// immediate generator.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_J    = 3'd3,
        IMM_U    = 3'd4,
        IMM_Z    = 3'd5,
        IMM_SH   = 3'd6,
        IMM_NONE = 3'd7
    } imm_sel_e;

    // Result is always built at 64 bits; narrower datapaths truncate. Only the
    // shift-amount width depends on XLEN, hence the rv64 flag.
    function automatic logic [63:0] imm_extract(input logic [31:0] inst,
                                                input imm_sel_e    sel,
                                                input logic        rv64);
        logic [63:0] imm;
        imm = '0;
        unique case (sel)
            IMM_I:    imm = {{52{inst[31]}}, inst[31:20]};
            IMM_S:    imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:    imm = {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_J:    imm = {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_U:    imm = {{32{inst[31]}}, inst[31:12], 12'b0};
            IMM_Z:    imm = {59'b0, inst[19:15]};
            IMM_SH:   imm = rv64 ? {58'b0, inst[25:20]} : {59'b0, inst[24:20]};
            IMM_NONE: imm = '0;
            default:  imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction, sized to the datapath width.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  imm_sel_e        sel,
    output logic [XLEN-1:0] imm
);

    assign imm = XLEN'(imm_extract(inst, sel, XLEN == 64));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and a 2-entry skid
// buffer (output register + skid register), strict FIFO order, flush support.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      inst_i,
    input  logic [2:0]       imm_sel_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [TAG_W-1:0] tag_o
);

    logic [XLEN-1:0]  dec_imm;
    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;

    logic accept;
    logic out_free;
    logic in_to_skid;
    logic skid_valid_nxt;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .inst (inst_i),
        .sel  (imm_sel_e'(imm_sel_i)),
        .imm  (dec_imm)
    );

    assign accept   = in_valid_i && in_ready_o;
    assign out_free = !out_valid_o || out_ready_i;

    // The skid entry always has priority for the output slot, so a new entry
    // parks in skid whenever the output is busy or the skid is being emptied.
    assign in_to_skid     = accept && (!out_free || skid_valid);
    assign skid_valid_nxt = in_to_skid || (skid_valid && !out_free);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of its neighbours.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            skid_valid  <= 1'b0;
            in_ready_o  <= 1'b1;
            imm_o       <= '0;
            tag_o       <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
            skid_valid  <= 1'b0;
            in_ready_o  <= 1'b1;
        end else begin
            skid_valid <= skid_valid_nxt;
            in_ready_o <= !skid_valid_nxt;
            if (out_free) begin
                out_valid_o <= skid_valid || accept;
                if (skid_valid) begin
                    imm_o <= skid_imm;
                    tag_o <= skid_tag;
                end else if (accept) begin
                    imm_o <= dec_imm;
                    tag_o <= tag_i;
                end
            end
        end
    end

    // NOTE: skid payload carries no reset; skid_valid alone qualifies it.
    always_ff @(posedge clk_i) begin
        if (in_to_skid) begin
            skid_imm <= dec_imm;
            skid_tag <= tag_i;
        end
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, registered immediate generator for the decode stage of the RISC-V pipeline. It extracts and sign- or zero-extends the immediate of a 32-bit instruction to XLEN bits, adds CSR-immediate and shift-amount formats, and carries a side-band tag (typically the PC). A valid/ready handshake and a 2-entry skid buffer let it sit between fetch and the ID/EX register with full-throughput stalls and flush.

## Interface
- XLEN, 32: datapath width; legal values 32, 64.
- TAG_W, 32: width of the pass-through tag.

- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  synchronous, active-low reset.
- flush_i  input  1  discard all held and incoming entries.
- in_valid_i  input  1  input entry valid.
- in_ready_o  output  1  block can accept an entry; registered.
- inst_i  input  32  instruction word.
- imm_sel_i  input  3  immediate format, imm_sel_e encoding.
- tag_i  input  TAG_W  side-band data carried alongside the entry.
- out_valid_o  output  1  output entry valid.
- out_ready_i  input  1  consumer accepts the output entry.
- imm_o  output  XLEN  extended immediate.
- tag_o  output  TAG_W  tag of the output entry.

## Operation
- imm_sel_e encodings and results, with s = inst[31] replicated to XLEN:
  - 0 I: s, inst[31:20].
  - 1 S: s, inst[31:25], inst[11:7].
  - 2 B: s, inst[7], inst[30:25], inst[11:8], 0.
  - 3 J: s, inst[19:12], inst[20], inst[30:21], 0.
  - 4 U: s above bit 31, inst[31:12], 12 zeros. RV64 sign-extends LUI/AUIPC.
  - 5 Z: zero-extended inst[19:15], the CSR uimm.
  - 6 SH: zero-extended inst[25:20] when XLEN=64, inst[24:20] when XLEN=32.
  - 7 NONE: all zeros.
- The immediate is computed combinationally at input and stored with tag_i. No combinational path from inputs to imm_o or tag_o.
- State:
  - Output register: out_valid_o, imm_o, tag_o.
  - Skid register: skid_valid, imm, tag.
- Accept = in_valid_i && in_ready_o. Drain = out_valid_o && out_ready_i.
- in_ready_o = !skid_valid, registered.
- Per cycle, when flush_i=0:
  - If the output is empty or drained, the output register loads the skid entry when skid_valid. Otherwise it loads the accepted entry. Otherwise out_valid_o clears.
  - An accepted entry goes to skid only when the output is full and not drained, or when the skid entry is moving to the output in the same cycle.
  - skid_valid clears when its entry moves to the output and no new entry enters skid.
- Ordering: strict FIFO. No entry is lost or duplicated.
- Hold rule: while out_valid_o && !out_ready_i, imm_o and tag_o stay stable.
- flush_i=1 (priority over everything):
  - out_valid_o and skid_valid clear next edge.
  - An entry presented the same cycle is dropped.
  - Data registers may keep stale values.

## Timing
- Reset (rst_ni=0 at an edge): out_valid_o=0, skid_valid=0, in_ready_o=1, imm_o=0, tag_o=0. Takes priority over flush_i.
- Reset mid-stream discards all entries. The first entry accepted after reset appears one cycle later.
- Latency: an entry accepted at edge n is on outputs after edge n, i.e. 1 cycle.
- Throughput: 1 entry/cycle while out_ready_i=1.
- Stall: in_ready_o drops the cycle after the skid fills. It rises the cycle after the skid empties.
- At most 2 entries held.
- in_valid_i with in_ready_o=0 is not accepted. The source holds its data.

## Structure
- Package imm_gen_pkg holds:
  - imm_sel_e, a 3-bit enum with values above.
  - Function imm_extract(inst, sel) parametrised on XLEN via a parameterised class static function or XLEN=64 with truncation.
- One natural sub-module: imm_decode (combinational extraction, XLEN parameter), instantiated once at the input.
- Handshake and skid logic stay in imm_gen_pipe.

## Test plan
- Formats, XLEN=32, out_ready_i=1, one cycle after each input:
  - 0xFFF00093 I → 0xFFFFFFFF.
  - 0xFE000EE3 B → 0xFFFFFFFC.
  - 0x0080006F J → 0x00000008.
  - 0x800000B7 U → 0x80000000.
  - 0x000FD073 Z → 0x0000001F.
  - sel 7 → 0.
- XLEN=64:
  - 0x800000B7 U → 0xFFFFFFFF80000000.
  - 0x03F09093 SH → 0x3F.
  - 0xFFF00093 I → all ones.
- Backpressure: stream tags 1..6 with in_valid_i held, out_ready_i=0 for cycles 2–4.
  - in_ready_o=0 after two entries held.
  - Output order 1..6, no duplicates.
  - imm_o/tag_o stable while stalled.
- Simultaneous fill/drain: skid full, out_ready_i=1 and in_valid_i=1 same cycle → skid entry to output, new entry to skid, in_ready_o stays 0.
- Flush: two entries held plus in_valid_i=1 with flush_i=1 → next cycle out_valid_o=0, in_ready_o=1, and the flushed-cycle entry never appears.
- Reset mid-operation: rst_ni=0 for 1 cycle with skid full → outputs at reset values. The entry accepted the following cycle appears one cycle later.
